// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential square-root unit.
// Consumers: sqrt_step, sqrt_seq (optional rounding controlled by SQRT_ROUND_EN).
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_OP_WIDTH = 16;

    function automatic int rad_w(input int op_w);
        return 2 * op_w;
    endfunction

    function automatic int rem_w(input int op_w);
        return op_w + 1;
    endfunction

    function automatic int trial_w(input int op_w);
        return op_w + 2;
    endfunction

    function automatic int cnt_w(input int op_w);
        return (op_w <= 2) ? 1 : $clog2(op_w);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: consumes two radicand
// bits and produces the next partial root and partial remainder.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int OP_WIDTH = DEF_OP_WIDTH
)
(
    input  logic [OP_WIDTH-1:0]        i_q,
    input  logic [rem_w(OP_WIDTH)-1:0] i_r,
    input  logic [1:0]                 i_bits,
    output logic [OP_WIDTH-1:0]        o_q_next,
    output logic [rem_w(OP_WIDTH)-1:0] o_r_next
);

    localparam int REM_W = rem_w(OP_WIDTH);
    localparam int EXT_W = trial_w(OP_WIDTH) + 1;

    // r' is kept one bit wider than needed so no bit of r is lost before the compare
    logic [EXT_W-1:0] w_trial;
    logic [EXT_W-1:0] w_t;
    logic             w_ge;

    // Trial subtraction and restore decision
    always_comb begin
        w_trial = {i_r, i_bits};
        w_t     = {1'b0, i_q, 2'b01};
        w_ge    = (w_trial >= w_t);
        if (w_ge) begin
            o_r_next = REM_W'(w_trial - w_t);
            o_q_next = OP_WIDTH'({i_q, 1'b1});
        end else begin
            o_r_next = REM_W'(w_trial);
            o_q_next = OP_WIDTH'({i_q, 1'b0});
        end
    end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential unsigned integer square root, one root bit per clock, valid/ready on both sides.
// Define SQRT_ROUND_EN to round the root to nearest (saturating); remainder stays truncated.
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int OP_WIDTH = DEF_OP_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*OP_WIDTH-1:0] radicand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_WIDTH-1:0]   root,
    output logic [OP_WIDTH:0]     remainder
);

    localparam int RAD_W = rad_w(OP_WIDTH);
    localparam int REM_W = rem_w(OP_WIDTH);
    localparam int CNT_W = cnt_w(OP_WIDTH);

    state_t              r_state;
    state_t              w_next_state;
    logic [RAD_W-1:0]    r_rad;
    logic [OP_WIDTH-1:0] r_q;
    logic [REM_W-1:0]    r_r;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_WIDTH-1:0] r_root;
    logic [REM_W-1:0]    r_rem;

    logic [OP_WIDTH-1:0] w_q_next;
    logic [REM_W-1:0]    w_r_next;
    logic [OP_WIDTH-1:0] w_root_final;
    logic                w_last;

    sqrt_step #(.OP_WIDTH(OP_WIDTH)) u_step (
        .i_q      (r_q),
        .i_r      (r_r),
        .i_bits   (r_rad[RAD_W-1 -: 2]),
        .o_q_next (w_q_next),
        .o_r_next (w_r_next)
    );

    assign w_last = (r_cnt == CNT_W'(OP_WIDTH - 1));

`ifdef SQRT_ROUND_EN
    // Round to nearest: x >= q^2+q+1 exactly when the truncated remainder exceeds q
    always_comb begin
        if (({1'b0, w_q_next} < w_r_next) && (w_q_next != {OP_WIDTH{1'b1}})) begin
            w_root_final = w_q_next + OP_WIDTH'(1);
        end else begin
            w_root_final = w_q_next;
        end
    end
`else
    // Floor root straight from the final iteration
    always_comb begin
        w_root_final = w_q_next;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next_state = CALC;
                else          w_next_state = IDLE;
            end
            CALC: begin
                if (w_last) w_next_state = DONE;
                else        w_next_state = CALC;
            end
            DONE: begin
                if (out_ready) w_next_state = IDLE;
                else           w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM handshake outputs, decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            CALC:    in_ready  = 1'b0;
            default: out_valid = 1'b0;
        endcase
    end

    // Iteration datapath; result registers only change on the last iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rad  <= {RAD_W{1'b0}};
            r_q    <= {OP_WIDTH{1'b0}};
            r_r    <= {REM_W{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
            r_root <= {OP_WIDTH{1'b0}};
            r_rem  <= {REM_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rad <= radicand;
                        r_q   <= {OP_WIDTH{1'b0}};
                        r_r   <= {REM_W{1'b0}};
                        r_cnt <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    r_rad <= {r_rad[RAD_W-3:0], 2'b00};
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_root <= w_root_final;
                        r_rem  <= w_r_next;
                    end
                end
                default: begin
                    r_root <= r_root;
                end
            endcase
        end
    end

    assign root      = r_root;
    assign remainder = r_rem;

endmodule

// File: doc/sqrt_seq.md
Name: sqrt_seq

Overview:
- Sequential unsigned integer square root. It is the inverse of the squaring multiplier: it takes a 2*OP_WIDTH-bit radicand and returns an OP_WIDTH-bit root plus the remainder.
- Uses the restoring digit-by-digit method: one root bit per clock, OP_WIDTH iterations.
- Sits in the ThresholdCutter path to recover magnitudes (e.g. RMS) from sum-of-squares values.
- Uses a valid/ready handshake on both input and output.

Parameters:
- OP_WIDTH, 16, root width; radicand width is 2*OP_WIDTH, remainder width is OP_WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  radicand present.
- in_ready  output  1  block can accept a radicand (high only in IDLE).
- radicand  input  2*OP_WIDTH  unsigned operand; sampled on the accept edge.
- out_valid  output  1  root/remainder valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- root  output  OP_WIDTH  floor(sqrt(radicand)); rounded variant under the optional feature.
- remainder  output  OP_WIDTH+1  radicand - floor_root^2; always less than or equal to 2*floor_root.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - State is IDLE; root, remainder, internal radicand shift register and counter are all 0.
  - out_valid = 0 and in_ready = 1 while rst is low after reset.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch radicand into the shift register, clear the partial root, remainder and counter, then go to CALC.
- CALC: OP_WIDTH clock edges, in_ready = 0, out_valid = 0. Each edge performs one iteration:
  - r' = (r << 2) | top two radicand bits (OP_WIDTH+2 bits wide).
  - t = (q << 2) | 1.
  - If r' >= t: r = r' - t and q = (q << 1) | 1.
  - Otherwise: r = r' and q = q << 1.
  - Shift the radicand register left by 2.
  - The counter counts 0..OP_WIDTH-1. On the edge where counter = OP_WIDTH-1, go to DONE.
- The subtract never underflows. The final r fits in OP_WIDTH+1 bits, and the upper bit of the r' path is dropped only after the compare.
- Latency: out_valid rises exactly OP_WIDTH clocks after the accept edge. Minimum issue interval is OP_WIDTH+2 clocks.
- DONE:
  - out_valid = 1; root and remainder are held stable.
  - On out_ready: go to IDLE, drop out_valid, and keep root/remainder at their last values (not cleared).
  - If out_ready is low, stay in DONE indefinitely; there is no loss or overwrite.
- in_valid during CALC or DONE is ignored; the upstream source must hold it.
- out_ready outside DONE has no effect.
- Reset asserted mid-CALC or mid-DONE aborts immediately to the reset state; a partial result is never presented.
- Radicand 0 produces root 0 and remainder 0. Radicand all-ones produces root 2^OP_WIDTH-1 and remainder 2^(OP_WIDTH+1)-2.

Optional Feature:
- SQRT_ROUND_EN:
  - Defined: on the final CALC edge, root is loaded with q+1 if the final r > q (round to nearest, since x >= q^2+q+1), saturating at 2^OP_WIDTH-1. remainder still reports the truncated remainder; latency is unchanged.
  - Undefined: root = floor, with no extra logic.

Decomposition:
- Package sqrt_pkg: state enum {IDLE, CALC, DONE}, and width helper constants (RAD_W = 2*OP_WIDTH, REM_W = OP_WIDTH+1, TRIAL_W = OP_WIDTH+2) as parameterised localparams/functions.
- One natural combinational sub-module, sqrt_step: inputs q, r and 2 radicand bits; outputs q_next and r_next.
- sqrt_seq instantiates one sqrt_step, plus the FSM, counter and registers.

Test Plan:
- radicand=144 -> after 16 cycles out_valid=1, root=12, remainder=0.
- radicand=99 -> root=9, remainder=18. With SQRT_ROUND_EN, root=10 and remainder=18.
- radicand=0 and radicand=0xFFFFFFFF -> root=0/rem=0 and root=65535/rem=131070 respectively. With SQRT_ROUND_EN, the all-ones case gives root=65535 (saturated).
- Backpressure on 1000: hold out_ready=0 for 20 cycles -> out_valid stays 1, root=31, remainder=39 stable; in_ready=0 throughout. A radicand presented meanwhile is not accepted until the cycle after out_ready.
- Reset mid-op: assert rst at CALC iteration 7 of radicand 65536 -> next cycle out_valid=0, in_ready=1, root=0. A fresh 65536 then gives root=256, remainder=0.
- Back-to-back: in_valid held high with 2, 3, 4 and out_ready=1 -> results (1,1), (1,2), (2,0) in order, spaced 18 cycles apart.
